// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, default frame geometry and
// the 2-of-3 vote helper. Also intended for use by the transmitter.
package uart_pkg;

  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_DATA_BITS  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  // 2-of-3 majority used to reject single-sample noise on the line
  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Receive-side byte handshake: the receiver (master) offers bytes and error
// pulses, the consumer (slave) answers with data_ready.
interface uart_receiver_if #(
  parameter int DATA_BITS = uart_pkg::DEF_DATA_BITS
);

  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 data_ready;
  logic                 frame_error;
  logic                 overrun;

  modport master (
    output data_out, data_valid, frame_error, overrun,
    input  data_ready
  );

  modport slave (
    input  data_out, data_valid, frame_error, overrun,
    output data_ready
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx pin. Resets to 1 so a
// reset never looks like a start bit.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Double-register the pin into the clk domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1-style UART receiver, LSB first, driven by an oversampling tick.
// Each bit is decided at mid-period by a 3-sample majority vote; good bytes
// land in a one-entry valid/ready output register.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  input  logic            rx_clk_en,
  input  logic            rx,
  uart_receiver_if.master bus
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] MID      = TW'(OVERSAMPLE / 2);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic                 rx_s;
  logic [2:0]           v;
  logic [2:0]           v_next;
  logic                 vote;
  uart_state_t          state, state_nxt;
  logic [TW-1:0]        tick_cnt, tick_cnt_nxt, tick_now;
  logic [BW-1:0]        bit_cnt, bit_cnt_nxt;
  logic                 armed, armed_nxt;
  logic [DATA_BITS-1:0] shift_reg, shift_reg_nxt;
  logic                 decision;
  logic                 load;
  logic                 ferr;

  uart_rx_sync u_sync (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  // The vote includes the sample taken on the current tick
  assign v_next   = {v[1:0], rx_s};
  assign vote     = majority3(v_next);
  assign tick_now = tick_cnt + 1'b1;
  assign decision = (state != ST_IDLE) && (tick_now == MID);

  // Shift the synchronised line into the vote window on every tick
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) v <= 3'b111;
    else if (rx_clk_en) v <= v_next;
  end

  // FSM and datapath registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= ST_IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      armed     <= 1'b0;
      shift_reg <= '0;
    end else begin
      state     <= state_nxt;
      tick_cnt  <= tick_cnt_nxt;
      bit_cnt   <= bit_cnt_nxt;
      armed     <= armed_nxt;
      shift_reg <= shift_reg_nxt;
    end
  end

  // Next-state logic; everything advances only on an oversample tick
  always_comb begin
    state_nxt     = state;
    tick_cnt_nxt  = tick_cnt;
    bit_cnt_nxt   = bit_cnt;
    armed_nxt     = armed;
    shift_reg_nxt = shift_reg;
    load          = 1'b0;
    ferr          = 1'b0;
    if (rx_clk_en) begin
      if (state != ST_IDLE) tick_cnt_nxt = tick_now;
      unique case (state)
        ST_IDLE: begin
          if (rx_s) begin
            armed_nxt = 1'b1;
          end else if (armed) begin
            state_nxt    = ST_START;
            tick_cnt_nxt = '0;
          end
        end
        ST_START: begin
          if (decision) begin
            if (vote) begin
              state_nxt = ST_IDLE;
            end else begin
              state_nxt   = ST_DATA;
              bit_cnt_nxt = '0;
            end
          end
        end
        ST_DATA: begin
          if (decision) begin
            shift_reg_nxt = {vote, shift_reg[DATA_BITS-1:1]};
            bit_cnt_nxt   = bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) state_nxt = ST_STOP;
          end
        end
        ST_STOP: begin
          if (decision) begin
            if (vote) load = 1'b1;
            else      ferr = 1'b1;
            state_nxt = ST_IDLE;
            armed_nxt = 1'b0;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // One-entry output register with overrun and frame-error pulses
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bus.data_out    <= '0;
      bus.data_valid  <= 1'b0;
      bus.frame_error <= 1'b0;
      bus.overrun     <= 1'b0;
    end else begin
      bus.frame_error <= ferr;
      bus.overrun     <= load & bus.data_valid & ~bus.data_ready;
      if (load) begin
        bus.data_out   <= shift_reg;
        bus.data_valid <= 1'b1;
      end else if (bus.data_valid && bus.data_ready) begin
        bus.data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: table of frames plus hand-written
// corner-case sequences, with a byte scoreboard fed by an output monitor.
`timescale 1ns/1ps
module tb_uart_receiver;
  import uart_pkg::*;

  localparam int TICK_DIV = 17;
  localparam int OVS      = 16;
  localparam int BIT_CLKS = TICK_DIV * OVS;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_fe;
    int         exp_vcyc;
  } vec_t;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  logic rx_clk_en = 1'b0;
  logic rx        = 1'b1;
  int   tick_div  = 0;

  logic [7:0] rec_data [0:63];
  int acc_cnt  = 0;
  int fe_cnt   = 0;
  int ov_cnt   = 0;
  int vcyc_cnt = 0;

  int checks = 0;
  int errors = 0;
  int rd_idx = 0;
  logic [7:0] exp_q[$];
  int fe0, ov0, vc0;
  vec_t vecs [5];

  uart_receiver_if #(.DATA_BITS(8)) bus ();

  uart_receiver #(.DATA_BITS(8), .OVERSAMPLE(OVS)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .rx_clk_en (rx_clk_en),
    .rx        (rx),
    .bus       (bus)
  );

  // 100 MHz-style system clock
  always #5 sys_clk = ~sys_clk;

  // Oversample tick: one-cycle pulse every TICK_DIV clocks
  always @(posedge sys_clk) begin
    if (tick_div == TICK_DIV - 1) begin
      tick_div  <= 0;
      rx_clk_en <= 1'b1;
    end else begin
      tick_div  <= tick_div + 1;
      rx_clk_en <= 1'b0;
    end
  end

  // Output monitor: records accepted bytes and counts pulses
  always @(negedge sys_clk) begin
    if (bus.data_valid)  vcyc_cnt <= vcyc_cnt + 1;
    if (bus.frame_error) fe_cnt   <= fe_cnt + 1;
    if (bus.overrun)     ov_cnt   <= ov_cnt + 1;
    if (bus.data_valid && bus.data_ready) begin
      rec_data[acc_cnt[5:0]] <= bus.data_out;
      acc_cnt <= acc_cnt + 1;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, actual, expected);
    end
  endtask

  task automatic drainScoreboard(input string name);
    while (rd_idx < acc_cnt) begin
      if (exp_q.size() == 0) checkOutput({name, " unexpected byte"}, int'(rec_data[rd_idx[5:0]]), 256);
      else checkOutput({name, " byte"}, int'(rec_data[rd_idx[5:0]]), int'(exp_q.pop_front()));
      rd_idx++;
    end
    checkOutput({name, " pending"}, exp_q.size(), 0);
  endtask

  task automatic idleClks(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic driveBit(input logic b);
    rx = b;
    idleClks(BIT_CLKS);
  endtask

  task automatic sendFrame(input logic [7:0] d, input logic stop);
    @(negedge sys_clk);
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) driveBit(d[i]);
    driveBit(stop);
    rx = 1'b1;
  endtask

  task automatic snapshot();
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    vc0 = vcyc_cnt;
  endtask

  task automatic applyStimulus(input vec_t v, input string name);
    snapshot();
    if (v.stop) exp_q.push_back(v.data);
    sendFrame(v.data, v.stop);
    idleClks(BIT_CLKS);
    checkOutput({name, " frame_error pulses"}, fe_cnt - fe0, v.exp_fe);
    checkOutput({name, " overrun pulses"}, ov_cnt - ov0, 0);
    checkOutput({name, " valid cycles"}, vcyc_cnt - vc0, v.exp_vcyc);
    checkOutput({name, " valid idle"}, int'(bus.data_valid), 0);
    drainScoreboard(name);
  endtask

  task automatic checkResetOutputs(input string name);
    checkOutput({name, " data_out"}, int'(bus.data_out), 0);
    checkOutput({name, " data_valid"}, int'(bus.data_valid), 0);
    checkOutput({name, " frame_error"}, int'(bus.frame_error), 0);
    checkOutput({name, " overrun"}, int'(bus.overrun), 0);
  endtask

  initial begin
    vecs[0] = '{8'h55, 1'b1, 0, 1};
    vecs[1] = '{8'hA3, 1'b1, 0, 1};
    vecs[2] = '{8'h7E, 1'b0, 1, 0};
    vecs[3] = '{8'h00, 1'b1, 0, 1};
    vecs[4] = '{8'hFF, 1'b1, 0, 1};

    bus.data_ready = 1'b1;
    sys_rst_n = 1'b0;
    idleClks(5);
    checkResetOutputs("reset");
    sys_rst_n = 1'b1;
    idleClks(2 * BIT_CLKS);

    // Frames with the consumer always ready, including a bad stop bit
    for (int i = 0; i < 5; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Overrun: two bytes with the consumer stalled
    bus.data_ready = 1'b0;
    snapshot();
    sendFrame(8'h12, 1'b1);
    idleClks(BIT_CLKS / 2);
    checkOutput("stall first valid", int'(bus.data_valid), 1);
    checkOutput("stall first data", int'(bus.data_out), 'h12);
    sendFrame(8'h34, 1'b1);
    idleClks(BIT_CLKS / 2);
    checkOutput("stall overrun pulses", ov_cnt - ov0, 1);
    checkOutput("stall data_out", int'(bus.data_out), 'h34);
    checkOutput("stall valid held", int'(bus.data_valid), 1);
    exp_q.push_back(8'h34);
    @(posedge sys_clk);
    #1 bus.data_ready = 1'b1;
    @(posedge sys_clk);
    #1 checkOutput("stall valid drop", int'(bus.data_valid), 0);
    drainScoreboard("stall");

    // Three-tick low glitch on an idle line is a false start
    snapshot();
    @(negedge sys_clk);
    rx = 1'b0;
    idleClks(3 * TICK_DIV);
    rx = 1'b1;
    idleClks(2 * BIT_CLKS);
    checkOutput("glitch frame_error", fe_cnt - fe0, 0);
    checkOutput("glitch valid cycles", vcyc_cnt - vc0, 0);
    exp_q.push_back(8'hC3);
    sendFrame(8'hC3, 1'b1);
    idleClks(BIT_CLKS);
    drainScoreboard("after glitch");

    // One-tick low spike in the middle of bit 2 of 0xFF
    snapshot();
    exp_q.push_back(8'hFF);
    @(negedge sys_clk);
    driveBit(1'b0);
    driveBit(1'b1);
    driveBit(1'b1);
    rx = 1'b1;
    idleClks(BIT_CLKS / 2 - TICK_DIV / 2);
    rx = 1'b0;
    idleClks(TICK_DIV);
    rx = 1'b1;
    idleClks(BIT_CLKS - (BIT_CLKS / 2 - TICK_DIV / 2) - TICK_DIV);
    for (int i = 3; i < 9; i++) driveBit(1'b1);
    idleClks(BIT_CLKS);
    checkOutput("spike frame_error", fe_cnt - fe0, 0);
    checkOutput("spike data_out", int'(bus.data_out), 'hFF);
    drainScoreboard("spike");

    // Reset in the middle of the data bits, then a clean frame
    @(negedge sys_clk);
    driveBit(1'b0);
    driveBit(1'b1);
    driveBit(1'b0);
    idleClks(BIT_CLKS / 2);
    sys_rst_n = 1'b0;
    rx = 1'b1;
    idleClks(3);
    checkResetOutputs("mid-frame reset");
    sys_rst_n = 1'b1;
    idleClks(2 * BIT_CLKS);
    snapshot();
    exp_q.push_back(8'h81);
    sendFrame(8'h81, 1'b1);
    idleClks(BIT_CLKS);
    checkOutput("post-reset frame_error", fe_cnt - fe0, 0);
    drainScoreboard("post-reset");

    // Break: line held low for two frames gives a single frame error
    snapshot();
    @(negedge sys_clk);
    rx = 1'b0;
    idleClks(20 * BIT_CLKS);
    rx = 1'b1;
    idleClks(2 * BIT_CLKS);
    checkOutput("break frame_error", fe_cnt - fe0, 1);
    checkOutput("break valid cycles", vcyc_cnt - vc0, 0);
    drainScoreboard("break");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
